// File: rtl/scan_test_sequencer.sv
// Scan-test sequencer: drives scan enable, shift/capture clock enables and
// test-shell holds through N load/capture patterns plus a final unload.
module scan_test_sequencer #(
    parameter int CHAIN_LEN  = 64,
    parameter int CNT_W      = 8,
    parameter int PAT_W      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] num_patterns,
    input  logic [1:0]       capture_cycles,
    output logic             se,
    output logic             shift_en,
    output logic             capture_en,
    output logic             hold_inputs,
    output logic             hold_outputs,
    output logic [CNT_W-1:0] shift_cnt,
    output logic [PAT_W-1:0] pattern_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HOLD, ST_SHIFT, ST_SE_FALL, ST_CAPTURE,
        ST_SE_RISE, ST_UNLOAD, ST_RELEASE, ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PAT_W-1:0] r_npat;
    logic [1:0]       r_cap;
    logic             r_abt;
    logic             w_accept, w_abort_go;
    logic             w_settle_end, w_shift_end, w_cap_end, w_last_pat;
    logic             w_shifting;

    assign w_settle_end = (r_cnt == SETTLE_LAST);
    assign w_shift_end  = (r_cnt == SHIFT_LAST);
    assign w_cap_end    = (r_cnt == CNT_W'(r_cap - 2'd1));
    assign w_last_pat   = (pattern_idx == r_npat - PAT_W'(1));

    // Next-state decode; abort overrides every active state except the release tail
    always_comb begin
        w_nxt      = r_state;
        w_accept   = 1'b0;
        w_abort_go = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    w_nxt    = (num_patterns == '0) ? ST_DONE : ST_HOLD;
                end
            end
            ST_HOLD:    if (w_settle_end) w_nxt = ST_SHIFT;
            ST_SHIFT:   if (w_shift_end)  w_nxt = ST_SE_FALL;
            ST_SE_FALL: if (w_settle_end) w_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_cap_end)    w_nxt = ST_SE_RISE;
            ST_SE_RISE: if (w_settle_end) w_nxt = w_last_pat ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:  if (w_shift_end)  w_nxt = ST_RELEASE;
            ST_RELEASE: if (w_settle_end) w_nxt = ST_DONE;
            ST_DONE:    w_nxt = ST_IDLE;
            default:    w_nxt = ST_IDLE;
        endcase
        if (abort && r_state != ST_IDLE && r_state != ST_RELEASE && r_state != ST_DONE) begin
            w_nxt      = ST_RELEASE;
            w_abort_go = 1'b1;
        end
        // counter restarts on every state change, so each phase counts from 0
        if (w_nxt == r_state && r_state != ST_IDLE)
            w_cnt_nxt = r_cnt + CNT_W'(1);
        else
            w_cnt_nxt = '0;
    end

    assign w_shifting = (w_nxt == ST_SHIFT) || (w_nxt == ST_UNLOAD);

    // State, phase counter and configuration sampled on accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_npat  <= '0;
            r_cap   <= '0;
            r_abt   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_npat <= num_patterns;
                r_cap  <= (capture_cycles == 2'd0) ? 2'd1 : capture_cycles;
                r_abt  <= 1'b0;
            end else if (w_abort_go) begin
                r_abt  <= 1'b1;
            end
        end
    end

    // Registered outputs decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se           <= 1'b0;
            shift_en     <= 1'b0;
            capture_en   <= 1'b0;
            hold_inputs  <= 1'b0;
            hold_outputs <= 1'b0;
            shift_cnt    <= '0;
            pattern_idx  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            se           <= (w_nxt == ST_HOLD) || (w_nxt == ST_SE_RISE) || w_shifting;
            shift_en     <= w_shifting;
            capture_en   <= (w_nxt == ST_CAPTURE);
            hold_inputs  <= (w_nxt != ST_IDLE) && (w_nxt != ST_DONE);
            hold_outputs <= (w_nxt != ST_IDLE) && (w_nxt != ST_DONE);
            busy         <= (w_nxt != ST_IDLE);
            done         <= (w_nxt == ST_DONE);
            // r_abt may still hold a previous run's abort when start goes straight to DONE
            aborted      <= (w_nxt == ST_DONE) && (r_state != ST_IDLE) && r_abt;
            if (w_shifting)
                shift_cnt <= w_cnt_nxt;
            else if (w_accept)
                shift_cnt <= '0;
            if (w_accept)
                pattern_idx <= '0;
            else if (r_state == ST_SE_RISE && w_nxt == ST_SHIFT)
                pattern_idx <= pattern_idx + PAT_W'(1);
        end
    end

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Directed bench for scan_test_sequencer with CHAIN_LEN=4, SETTLE_CYC=2.
module tb_scan_test_sequencer;

    localparam int L = 4;
    localparam int S = 2;

    logic       clk, rst_n, start, abort;
    logic [7:0] num_patterns;
    logic [1:0] capture_cycles;
    logic       se, shift_en, capture_en, hold_inputs, hold_outputs;
    logic [7:0] shift_cnt, pattern_idx;
    logic       busy, done, aborted;

    int n_chk = 0;
    int n_err = 0;

    scan_test_sequencer #(.CHAIN_LEN(L), .CNT_W(8), .PAT_W(8), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_patterns(num_patterns), .capture_cycles(capture_cycles),
        .se(se), .shift_en(shift_en), .capture_en(capture_en),
        .hold_inputs(hold_inputs), .hold_outputs(hold_outputs),
        .shift_cnt(shift_cnt), .pattern_idx(pattern_idx),
        .busy(busy), .done(done), .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // per-run observations
    int   m_hold, m_shift, m_sblk, m_cap, m_cblk, m_cmin, m_cmax, m_inv, m_cnterr;
    int   m_done_c, m_first_shift, m_se_cnt, m_pidx, m_frozen;
    logic m_aborted, m_timeout, m_drop_ok, m_post_se, m_post_sh;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then watch every cycle until done (bounded); optionally abort
    // on the abort_at-th shift cycle and pulse start again at cycle busy_start_c.
    task automatic run(input int npat, input int ccyc, input int abort_at, input int busy_start_c);
        logic pse, psh, pcap, ph;
        int   cw, pos, ab_c;
        m_hold = 0; m_shift = 0; m_sblk = 0; m_cap = 0; m_cblk = 0; m_cmin = 99; m_cmax = 0;
        m_inv = 0; m_cnterr = 0; m_done_c = -1; m_first_shift = -1; m_se_cnt = 0; m_pidx = -1;
        m_frozen = -1; m_aborted = 1'bx; m_timeout = 1'b1; m_drop_ok = 1'b0;
        m_post_se = 1'bx; m_post_sh = 1'bx;
        pse = 0; psh = 0; pcap = 0; ph = 0; cw = 0; pos = 0; ab_c = -1;
        num_patterns = 8'(npat); capture_cycles = 2'(ccyc); start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (hold_inputs) m_hold++;
            if (hold_inputs !== hold_outputs) m_inv++;
            if (se) m_se_cnt++;
            if (shift_en) begin
                m_shift++;
                if (!psh) begin m_sblk++; pos = 0; end
                if (m_first_shift < 0) m_first_shift = c;
                if (int'(shift_cnt) != pos) m_cnterr++;
                pos++;
                if (!se) m_inv++;
            end
            if (capture_en) begin
                m_cap++; cw++;
                if (se) m_inv++;
            end
            if (!capture_en && pcap) begin
                m_cblk++;
                if (cw < m_cmin) m_cmin = cw;
                if (cw > m_cmax) m_cmax = cw;
                cw = 0;
            end
            if (shift_en && capture_en) m_inv++;
            if (se !== pse && (shift_en || capture_en)) m_inv++;
            if (!busy) m_inv++;
            if (ab_c > 0 && c == ab_c + 1) begin
                m_post_se = se; m_post_sh = shift_en; m_frozen = int'(shift_cnt);
            end
            if (done) begin
                m_done_c = c; m_aborted = aborted; m_pidx = int'(pattern_idx);
                m_drop_ok = ph && !hold_inputs; m_timeout = 1'b0;
                break;
            end
            pse = se; psh = shift_en; pcap = capture_en; ph = hold_inputs;
            if (abort_at > 0 && ab_c < 0 && shift_en && m_shift == abort_at) begin
                abort = 1'b1; ab_c = c;
            end
            if (c == busy_start_c) begin
                start = 1'b1; num_patterns = 8'd7;
            end
            tick();
            abort = 1'b0; start = 1'b0;
        end
        chk("run_timeout", m_timeout, 0);
        tick();   // leave the DONE cycle so the next start is accepted
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_patterns = '0; capture_cycles = '0;
        #3;
        chk("reset_outs", {se, shift_en, capture_en, hold_inputs, hold_outputs, busy, done, aborted,
                           shift_cnt, pattern_idx}, 0);
        #10 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_outs", {se, shift_en, capture_en, hold_inputs, hold_outputs, busy, done, aborted,
                          shift_cnt, pattern_idx}, 0);

        // two patterns, single capture; start mid-run must be ignored
        run(2, 1, 0, 10);
        chk("p2_hold",   m_hold, 26);
        chk("p2_shift",  m_shift, 12);
        chk("p2_sblk",   m_sblk, 3);
        chk("p2_cap",    m_cap, 2);
        chk("p2_cblk",   m_cblk, 2);
        chk("p2_cmax",   m_cmax, 1);
        chk("p2_first",  m_first_shift, S + 1);
        chk("p2_done_c", m_done_c, 27);
        chk("p2_drop",   m_drop_ok, 1);
        chk("p2_abt",    m_aborted, 0);
        chk("p2_pidx",   m_pidx, 1);
        chk("p2_inv",    m_inv, 0);
        chk("p2_cnt",    m_cnterr, 0);
        chk("p2_idle",   {done, busy, hold_inputs}, 0);

        // zero patterns: immediate done, nothing asserted
        run(0, 1, 0, 0);
        chk("p0_done_c", m_done_c, 1);
        chk("p0_hold",   m_hold, 0);
        chk("p0_se",     m_se_cnt, 0);
        chk("p0_en",     m_shift + m_cap, 0);
        chk("p0_abt",    m_aborted, 0);

        // capture_cycles 0 behaves as 1
        run(1, 0, 0, 0);
        chk("c0_cap",    m_cap, 1);
        chk("c0_cmin",   m_cmin, 1);
        chk("c0_hold",   m_hold, 17);
        chk("c0_done_c", m_done_c, 18);
        chk("c0_inv",    m_inv, 0);

        // capture_cycles 3, two patterns
        run(2, 3, 0, 0);
        chk("c3_cap",    m_cap, 6);
        chk("c3_cblk",   m_cblk, 2);
        chk("c3_cmin",   m_cmin, 3);
        chk("c3_cmax",   m_cmax, 3);
        chk("c3_hold",   m_hold, 30);
        chk("c3_done_c", m_done_c, 31);
        chk("c3_inv",    m_inv, 0);

        // abort on 2nd shift cycle of pattern 0, start while in RELEASE
        run(2, 1, 2, 5);
        chk("ab_se",     m_post_se, 0);
        chk("ab_sh",     m_post_sh, 0);
        chk("ab_frozen", m_frozen, 1);
        chk("ab_shift",  m_shift, 2);
        chk("ab_hold",   m_hold, 6);
        chk("ab_done_c", m_done_c, 7);
        chk("ab_drop",   m_drop_ok, 1);
        chk("ab_abt",    m_aborted, 1);
        chk("ab_pidx",   m_pidx, 0);
        chk("ab_inv",    m_inv, 0);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; num_patterns = 8'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("sa_idle", {busy, done, hold_inputs}, 0);

        // asynchronous reset during capture
        num_patterns = 8'd2; capture_cycles = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!capture_en && k < 60) begin tick(); k++; end
        chk("rs_reach_cap", capture_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async", {capture_en, hold_inputs, hold_outputs, busy, se}, 0);
        #1 rst_n = 1'b1;
        tick();
        run(1, 1, 0, 0);
        chk("rs_hold",   m_hold, 17);
        chk("rs_done_c", m_done_c, 18);
        chk("rs_pidx",   m_pidx, 0);
        chk("rs_abt",    m_aborted, 0);
        chk("rs_inv",    m_inv, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
